// File: rtl/demux4b_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer: gathers four WIDTH-bit words into channel registers a-d
// and holds the frame until frame_ack. Define DEMUX_AUTO_SEL_EN for round-robin channel select.
module demux4b_1_to_4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select1,
    input  logic             select0,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       vld,
    output logic             frame_done,
    output logic             ovr,
    output logic             dbg_state
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       sel;
    logic [3:0]       sel_1h;
    logic [3:0]       vld_q;
    logic [3:0]       vld_upd;
    logic             xfer;
    logic             complete;
    logic             ovr_q;
    logic             done_q;
    logic [WIDTH-1:0] ch_q [4];

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] cnt_q;
    assign sel = cnt_q;
`else
    assign sel = {select1, select0};
`endif

    // Handshake: a word moves only on a clock edge where in_valid && in_ready;
    // in_ready depends on state alone, never on in_valid.
    always_comb begin
        in_ready = (state_q == FILL);
        xfer     = in_valid && in_ready;
        sel_1h   = 4'b0001 << sel;
        vld_upd  = vld_q | sel_1h;
        // A flush in the same cycle drops the word, so it cannot complete a frame.
        complete = xfer && !frame_ack && (vld_upd == 4'b1111);
        state_d  = state_q;
        case (state_q)
            FILL: if (complete) state_d = FULL;
            FULL: if (frame_ack) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) ch_q[i] <= '0;
            vld_q  <= 4'b0000;
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef DEMUX_AUTO_SEL_EN
            cnt_q  <= 2'd0;
`endif
        end else begin
            done_q <= complete;
            if (frame_ack) begin
                vld_q <= 4'b0000;
                ovr_q <= 1'b0;
`ifdef DEMUX_AUTO_SEL_EN
                cnt_q <= 2'd0;
`endif
            end else if (xfer) begin
                ch_q[sel] <= in_data;
                vld_q     <= vld_upd;
                if (vld_q[sel]) ovr_q <= 1'b1;
`ifdef DEMUX_AUTO_SEL_EN
                cnt_q     <= cnt_q + 2'd1;
`endif
            end
        end
    end

    assign a          = ch_q[0];
    assign b          = ch_q[1];
    assign c          = ch_q[2];
    assign d          = ch_q[3];
    assign vld        = vld_q;
    assign ovr        = ovr_q;
    assign frame_done = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_demux4b_1_to_4_reg.sv
// Bench for demux4b_1_to_4_reg: directed frames; completed frames are checked by a monitor
// against an expected queue, other behaviour by direct checks. Auto-select path under DEMUX_AUTO_SEL_EN.
module tb_demux4b_1_to_4_reg;

    localparam int WIDTH = 4;
    localparam int EW    = 4 * WIDTH + 5;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             select1;
    logic             select0;
    logic             frame_ack;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       vld;
    logic             frame_done;
    logic             ovr;
    logic             dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    demux4b_1_to_4_reg #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .select1(select1), .select0(select0),
        .frame_ack(frame_ack), .a(a), .b(b), .c(c), .d(d), .vld(vld),
        .frame_done(frame_done), .ovr(ovr), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (act=running exp=done)");
        $fatal(1, "timeout");
    end

    function automatic logic [EW-1:0] pack(input logic [3:0] pa, input logic [3:0] pb,
                                           input logic [3:0] pc, input logic [3:0] pd,
                                           input logic [3:0] pv, input logic po);
        return {pa, pb, pc, pd, pv, po};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic send(input logic [3:0] data, input logic [1:0] sel);
        in_valid = 1'b1;
        in_data  = data;
        {select1, select0} = sel;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic ack(input logic with_xfer, input logic [3:0] data, input logic [1:0] sel);
        frame_ack = 1'b1;
        in_valid  = with_xfer;
        in_data   = data;
        {select1, select0} = sel;
        @(posedge clock); #1;
        frame_ack = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock); #1;
    endtask

    // monitor / scoreboard: every frame_done pulse must match the next expected frame
    always @(negedge clock) begin
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 32'(frame_done), 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("frame", 32'(pack(a, b, c, d, vld, ovr)), 32'(e));
            end
        end
    end

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0;
        select1 = 1'b0; select0 = 1'b0; frame_ack = 1'b0;
        #23 reset = 1'b0;
        @(posedge clock); #1;

        check("rst_abcd", 32'({a, b, c, d}), 32'h0);
        check("rst_vld", 32'(vld), 32'h0);
        check("rst_flags", 32'({frame_done, ovr, in_ready, dbg_state}), 32'b0010);

`ifndef DEMUX_AUTO_SEL_EN
        // frame 1, manual select
        send(4'hA, 2'b00);
        check("write_lat_a", 32'({a, vld}), 32'hA1);
        send(4'h5, 2'b01);
        send(4'h3, 2'b10);
        exp_q.push_back(pack(4'hA, 4'h5, 4'h3, 4'hC, 4'hF, 1'b0));
        send(4'hC, 2'b11);
        check("full_in_ready", 32'({in_ready, dbg_state}), 32'b01);

        // FULL hold with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'hF; {select1, select0} = 2'b00;
            @(posedge clock); #1;
            check("hold_abcd", 32'({a, b, c, d}), 32'hA53C);
            check("hold_vld_done", 32'({vld, frame_done, in_ready}), 32'({4'hF, 2'b00}));
        end
        in_valid = 1'b0;
        ack(1'b0, 4'h0, 2'b00);
        check("ack_release", 32'({vld, in_ready, dbg_state}), 32'({4'h0, 2'b10}));

        // overwrite of channel b
        send(4'h1, 2'b01);
        send(4'h2, 2'b01);
        check("ovr_b", 32'({b, vld, ovr}), 32'({4'h2, 4'b0010, 1'b1}));
        ack(1'b0, 4'h0, 2'b00);
        check("ovr_clear", 32'({vld, ovr, b}), 32'({4'h0, 1'b0, 4'h2}));

        // flush colliding with a transfer: word to c must be dropped
        send(4'h6, 2'b00);
        send(4'h7, 2'b01);
        check("pre_flush_vld", 32'(vld), 32'b0011);
        ack(1'b1, 4'hF, 2'b10);
        check("flush_vld", 32'({vld, ovr, in_ready}), 32'({4'h0, 2'b01}));
        check("flush_data_kept", 32'({a, b, c, d}), 32'h673C);

        // frame with an overwrite inside, then back-to-back ack and transfer
        send(4'h1, 2'b00);
        send(4'h2, 2'b00);
        send(4'h4, 2'b01);
        send(4'h6, 2'b10);
        exp_q.push_back(pack(4'h2, 4'h4, 4'h6, 4'h8, 4'hF, 1'b1));
        send(4'h8, 2'b11);
        check("frame2_done_pulse", 32'({frame_done, dbg_state}), 32'b11);
        ack(1'b0, 4'h0, 2'b00);
        check("done_one_cycle", 32'(frame_done), 32'd0);
        send(4'h9, 2'b11);
        check("b2b_write", 32'({d, vld, in_ready}), 32'({4'h9, 4'b1000, 1'b1}));
        ack(1'b0, 4'h0, 2'b00);

        // async reset mid-frame
        send(4'hE, 2'b00);
        send(4'hD, 2'b01);
        #3 reset = 1'b1;
        #1;
        check("async_abcd", 32'({a, b, c, d}), 32'h0);
        check("async_flags", 32'({vld, frame_done, ovr, in_ready, dbg_state}), 32'({4'h0, 4'b0010}));
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_vld", 32'(vld), 32'h0);
`else
        // auto mode: select inputs are driven with junk to show they are ignored
        send(4'h1, 2'b11);
        send(4'h2, 2'b11);
        send(4'h3, 2'b00);
        exp_q.push_back(pack(4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 1'b0));
        send(4'h4, 2'b01);
        check("auto_full", 32'({in_ready, dbg_state}), 32'b01);
        ack(1'b0, 4'h0, 2'b00);
        send(4'h9, 2'b10);
        check("auto_after_ack", 32'({a, vld, ovr}), 32'({4'h9, 4'b0001, 1'b0}));
        send(4'h5, 2'b00);
        check("auto_b", 32'({b, vld}), 32'({4'h5, 4'b0011}));
        ack(1'b1, 4'h7, 2'b00);
        check("auto_flush", 32'({vld, c}), 32'({4'h0, 4'h3}));
        send(4'h8, 2'b11);
        check("auto_cnt_cleared", 32'({a, vld}), 32'({4'h8, 4'b0001}));
        send(4'hB, 2'b11);
        #3 reset = 1'b1;
        #1;
        check("auto_async", 32'({a, b, c, d, vld, ovr, in_ready}), 32'({16'h0, 4'h0, 2'b01}));
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        send(4'hC, 2'b10);
        check("auto_cnt_reset", 32'({a, vld}), 32'({4'hC, 4'b0001}));
`endif

        idle();
        idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
